alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage A computes result/carry/overflow, stage B adds
// zero/negative and presents the result under valid/ready handshake.
module alu_pipe #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             use_cf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   typedef enum logic [2:0] {
      OP_PASS = 3'b000,
      OP_RSV1 = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_RSV7 = 3'b111
   } op_e;

   logic             a_valid_q, a_valid_d;
   logic [WIDTH-1:0] a_res_q,   a_res_d;
   logic             a_c_q,     a_c_d;
   logic             a_v_q,     a_v_d;
   logic             b_valid_q, b_valid_d;
   logic [WIDTH-1:0] b_res_q,   b_res_d;
   logic [3:0]       b_flags_q, b_flags_d;
   logic             cf_q,      cf_d;

   logic             stall, in_xfer, is_arith, cin;
   logic [WIDTH-1:0] b_eff, alu_res;
   logic [WIDTH:0]   sum;
   logic             alu_c, alu_v;
   op_e              op_sel;

   assign stall    = b_valid_q & ~out_ready;
   assign in_ready = ~stall;
   assign in_xfer  = in_valid & in_ready;

   // Subtraction is a + ~b + cin, so the carry flag is an inverted borrow.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      op_sel   = op_e'(op);
      is_arith = (op_sel == OP_ADD) || (op_sel == OP_SUB);
      b_eff    = (op_sel == OP_SUB) ? ~b : b;
      cin      = use_cf ? cf_q : (op_sel == OP_SUB);
      sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (op_sel)
         OP_PASS: alu_res = b;
         OP_ADD, OP_SUB: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      a_valid_d = a_valid_q;
      a_res_d   = a_res_q;
      a_c_d     = a_c_q;
      a_v_d     = a_v_q;
      b_valid_d = b_valid_q;
      b_res_d   = b_res_q;
      b_flags_d = b_flags_q;
      cf_d      = cf_q;
      if (!stall) begin
         a_valid_d = in_xfer;
         if (in_xfer) begin
            a_res_d = alu_res;
            a_c_d   = alu_c;
            a_v_d   = alu_v;
         end
         b_valid_d = a_valid_q;
         b_res_d   = a_res_q;
         b_flags_d = {a_res_q[WIDTH-1], (a_res_q == '0), a_v_q, a_c_q};
      end
      // Updated at acceptance, not at retirement, so chained use_cf ops need no gap.
      if (in_xfer && is_arith) cf_d = alu_c;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_valid_q <= 1'b0;
         a_res_q   <= '0;
         a_c_q     <= 1'b0;
         a_v_q     <= 1'b0;
         b_valid_q <= 1'b0;
         b_res_q   <= '0;
         b_flags_q <= '0;
         cf_q      <= 1'b0;
      end else begin
         a_valid_q <= a_valid_d;
         a_res_q   <= a_res_d;
         a_c_q     <= a_c_d;
         a_v_q     <= a_v_d;
         b_valid_q <= b_valid_d;
         b_res_q   <= b_res_d;
         b_flags_q <= b_flags_d;
         cf_q      <= cf_d;
      end
   end

   assign out_valid = b_valid_q;
   assign result    = b_res_q;
   assign flags     = b_flags_q;

endmodule
